// File: rtl/ah_cam_gen.sv
// Content-addressable store with free-index recirculation and registered lowest-index search.
// Optional occupancy output enabled by defining AH_CAM_OCC_COUNT_EN.

module ah_cam_gen_entry #(
    parameter int DW = 128,
    parameter int KW = 68
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    input  logic          clr,
    input  logic [KW-1:0] key,
    output logic [DW-1:0] data,
    output logic          vld,
    output logic          match
);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data <= '0;
            vld  <= 1'b0;
        end else begin
            if (we) data <= wdata;
            // A location being written is never the one being consumed, so order is moot.
            if (we)       vld <= 1'b1;
            else if (clr) vld <= 1'b0;
        end
    end

    assign match = vld && (data[KW-1:0] == key);
endmodule

module ah_cam_gen #(
    parameter int DEPTH = 20,
    parameter int DW    = 128,
    parameter int KW    = 68,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] wdata,
    input  logic          wvalid,
    output logic          wready,
    output logic [AW-1:0] widx,
    input  logic [KW-1:0] skey,
    input  logic          svalid,
    input  logic          sconsume,
    output logic          rvalid,
    output logic          rhit,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ridx,
`ifdef AH_CAM_OCC_COUNT_EN
    output logic [AW:0]   occ,
`endif
    output logic          full,
    output logic          empty
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic [DEPTH-1:0]         ent_vld;
    logic [DEPTH-1:0]         ent_match;
    logic [DEPTH-1:0]         ent_we;
    logic [DEPTH-1:0]         ent_clr;

    logic [AW:0]   fill_cnt;
    logic [AW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fill_done, fifo_empty;

    logic          hit;
    logic [AW-1:0] hit_idx;
    logic [DW-1:0] hit_data;
    logic          wr_fire, cons_fire, fifo_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign fill_done  = (fill_cnt == DEPTH_C);
    assign fifo_empty = (fifo_cnt == '0);
    assign full       = fill_done & fifo_empty;
    assign wready     = ~full;
    assign widx       = fill_done ? fifo_mem[rd_ptr] : fill_cnt[AW-1:0];
    assign empty      = ~|ent_vld;

    assign wr_fire   = wvalid & wready;
    assign fifo_pop  = wr_fire & fill_done;
    assign cons_fire = svalid & sconsume & hit;

    // Descending scan so the lowest matching index is the last one assigned.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_data = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (ent_match[i]) begin
                hit      = 1'b1;
                hit_idx  = AW'(i);
                hit_data = ent_data[i];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign ent_we[g]  = wr_fire   && (widx    == AW'(g));
        assign ent_clr[g] = cons_fire && (hit_idx == AW'(g));

        ah_cam_gen_entry #(.DW(DW), .KW(KW)) u_ent (
            .clk   (clk),
            .rstn  (rstn),
            .we    (ent_we[g]),
            .wdata (wdata),
            .clr   (ent_clr[g]),
            .key   (skey),
            .data  (ent_data[g]),
            .vld   (ent_vld[g]),
            .match (ent_match[g])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_cnt <= '0;
        end else if (wr_fire && !fill_done) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    // A freed index is pushed at the edge, so it is only visible at widx next cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (cons_fire) begin
                fifo_mem[wr_ptr] <= hit_idx;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (fifo_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({cons_fire, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid <= 1'b0;
            rhit   <= 1'b0;
            rdata  <= '0;
            ridx   <= '0;
        end else begin
            rvalid <= svalid;
            rhit   <= svalid & hit;
            rdata  <= (svalid & hit) ? hit_data : '0;
            ridx   <= (svalid & hit) ? hit_idx  : '0;
        end
    end

`ifdef AH_CAM_OCC_COUNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ <= '0;
        end else begin
            case ({wr_fire, cons_fire})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
`endif
endmodule

// File: doc/ah_cam_gen.md
AH_CAM_GEN -- requirements
Module: ah_cam_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 20: number of CAM entries; legal range 2 to 256.
REQ-002 SHALL have parameter DW, default 128: stored entry width in bits.
REQ-003 SHALL have parameter KW, default 68: key width compared against entry bits [KW-1:0]; KW SHALL be less than or equal to DW.
REQ-004 SHALL define derived width AW = clog2(DEPTH).
REQ-005 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port wdata, input, DW: entry to store.
REQ-008 SHALL have port wvalid, input, 1: write request.
REQ-009 SHALL have port wready, output, 1: a free location exists.
REQ-010 SHALL have port widx, output, AW: location the current write will occupy.
REQ-011 SHALL have port skey, input, KW: search key.
REQ-012 SHALL have port svalid, input, 1: search request.
REQ-013 SHALL have port sconsume, input, 1: on a hit, invalidate the matching entry and free its location.
REQ-014 SHALL have port rvalid, output, 1: search result valid.
REQ-015 SHALL have port rhit, output, 1: search hit.
REQ-016 SHALL have port rdata, output, DW: data of the matching entry.
REQ-017 SHALL have port ridx, output, AW: index of the matching entry.
REQ-018 SHALL have port full, output, 1: no free location.
REQ-019 SHALL have port empty, output, 1: no valid entry.

Function
REQ-020 SHALL accept a write only on a cycle where wvalid and wready are both high; the entry data and its valid bit SHALL be set at that clock edge.
REQ-021 SHALL allocate locations from a fill counter 0..DEPTH-1 until the counter saturates at DEPTH, and thereafter from a DEPTH-deep recirculation FIFO of freed indices, in FIFO order.
REQ-022 SHALL drive widx combinationally: the fill counter value while the counter is below DEPTH, otherwise the FIFO head.
REQ-023 SHALL drive wready = ~full, where full = (counter == DEPTH) & FIFO empty.
REQ-024 SHALL compare skey only against entries whose valid bit is set.
REQ-025 SHALL register the search result so that rvalid is high exactly one cycle after svalid.
REQ-026 SHALL select the lowest matching index when several entries hit.
REQ-027 SHALL drive rhit=0, rdata=0 and ridx=0 on a miss.
REQ-028 SHALL, on svalid & sconsume & hit, clear that entry's valid bit and push its index into the FIFO at the same edge that registers the result.
REQ-029 SHALL evaluate a search using the pre-edge contents when a write occurs in the same cycle; the new entry is visible from the next cycle.
REQ-030 SHALL NOT make a location freed this cycle allocatable before the next cycle.
REQ-031 SHALL perform a simultaneous write and consume in the same cycle independently.
REQ-032 SHALL drive empty high when no entry's valid bit is set.
REQ-033 SHALL ignore a write attempted while full, with no state change.

Reset
REQ-034 SHALL, while rstn is low, clear all valid bits and entry data to 0, set the fill counter to 0, empty the FIFO, and hold rvalid=0, rhit=0, rdata=0 and ridx=0.
REQ-035 SHALL hold wready=1, full=0, empty=1 and widx=0 during reset.
REQ-036 SHALL discard any in-flight search result when reset asserts mid-operation.

Configuration
REQ-037 SHALL, when macro AH_CAM_OCC_COUNT_EN is defined, add output occ (width AW+1) equal to the number of valid entries: +1 per write, -1 per consume, unchanged on a simultaneous write and consume, reset value 0.
REQ-038 SHALL, without AH_CAM_OCC_COUNT_EN, omit the occ port and its counter; all other behaviour is identical.

Verification (DEPTH=4, DW=16, KW=8)
REQ-039 SHALL cover: reset, then write 0x1111, 0x2222, 0x3333 and 0x4444 -> widx 0,1,2,3; full=1 after the 4th write; a 5th write is ignored.
REQ-040 SHALL cover: search skey=0x33 without consume -> next cycle rvalid=1, rhit=1, ridx=2, rdata=0x3333; full stays 1.
REQ-041 SHALL cover: search 0x22 with consume, then write 0xAA55 -> ridx=1; widx=1 on the following cycle; a search of 0x55 then hits ridx=1.
REQ-042 SHALL cover: entries 0x0177 and 0x0277 both present, search 0x77 -> ridx equals the lower index; search 0x99 -> rhit=0, rdata=0.
REQ-043 SHALL cover: a write and a search of the same key in the same cycle -> miss; the same search in the next cycle -> hit.
REQ-044 SHALL cover: rstn pulsed low with svalid high mid-operation -> rvalid=0 and empty=1; with AH_CAM_OCC_COUNT_EN, occ=0.
